// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Define SERIAL_TX_PARITY_EN to add the even-parity bit between the last data bit and the stop bit.
module serial_frame_tx #(
  parameter int WIDTH    = 8,
  parameter int BAUD_DIV = 4
) (
  input  logic             C,
  input  logic             RN,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             VALID_IN,
  output logic             READY_OUT,
  output logic             TX_OUT,
  output logic             BUSY_OUT,
  output logic             DONE_OUT
);

  localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  // Next-state logic. Outputs are decoded from the *next* state so that the
  // registered outputs line up with the state they describe.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif

    if (state_q == S_IDLE) begin
      if (VALID_IN) begin
        state_d = S_START;
        shift_d = DATA_IN;
        baud_d  = '0;
        bit_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
        parity_d = ^DATA_IN;
`endif
      end
    end else if (baud_q != BAUD_LAST) begin
      baud_d = baud_q + BAUD_W'(1);
    end else begin
      baud_d = '0;
      case (state_q)
        S_START: begin
          state_d = S_DATA;
          bit_d   = '0;
        end
        S_DATA: begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY: state_d = S_STOP;
`endif
        S_STOP:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_STOP) && (baud_d == BAUD_LAST);
  end

  always_ff @(posedge C) begin
    if (!RN) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign TX_OUT    = tx_q;
  assign READY_OUT = ready_q;
  assign BUSY_OUT  = busy_q;
  assign DONE_OUT  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: WIDTH=8 at BAUD_DIV=4 and BAUD_DIV=1.
// Works with or without SERIAL_TX_PARITY_EN defined.
module tb_serial_frame_tx;

`ifdef SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int BD = 4;
  localparam int NB = 10 + P;

  logic       C;
  logic       RN;
  logic [7:0] DATA_IN, d1;
  logic       VALID_IN, v1;
  logic       READY_OUT, TX_OUT, BUSY_OUT, DONE_OUT;
  logic       r1, tx1, b1, dn1;

  int tests = 0;
  int failed = 0;

  serial_frame_tx #(.WIDTH(8), .BAUD_DIV(BD)) u_dut (
    .C(C), .RN(RN), .DATA_IN(DATA_IN), .VALID_IN(VALID_IN),
    .READY_OUT(READY_OUT), .TX_OUT(TX_OUT), .BUSY_OUT(BUSY_OUT), .DONE_OUT(DONE_OUT)
  );

  serial_frame_tx #(.WIDTH(8), .BAUD_DIV(1)) u_fast (
    .C(C), .RN(RN), .DATA_IN(d1), .VALID_IN(v1),
    .READY_OUT(r1), .TX_OUT(tx1), .BUSY_OUT(b1), .DONE_OUT(dn1)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    string      name;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge C);
    #1;
  endtask

  // Reference frame from the frame rules: bit 0 start, 1..8 data LSB first,
  // then parity (even, when compiled in) and the stop bit; unused upper bits are 1.
  function automatic logic [10:0] model_frame(input logic [7:0] w);
    logic [10:0] f;
    int ones;
    f = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = w[i];
      ones += int'(w[i]);
    end
    if (P == 1) f[9] = ones[0];
    return f;
  endfunction

  function automatic logic [10:0] table_frame(input logic [7:0] w, input logic par);
`ifdef SERIAL_TX_PARITY_EN
    return {1'b1, par, w, 1'b0};
`else
    return {2'b11, w, 1'b0} | {par, 10'b0} | 11'h400;
`endif
  endfunction

  function automatic logic [3:0] main_outs();
    return {TX_OUT, READY_OUT, BUSY_OUT, DONE_OUT};
  endfunction

  // Precondition: main DUT idle. Sends w, checks every cycle of the frame and
  // the first idle cycle after it. After accept, VALID_IN/DATA_IN take hold_v/next_d.
  task automatic send_frame(input logic [7:0] w, input logic [10:0] fr,
                            input logic hold_v, input logic [7:0] next_d, input string name);
    VALID_IN = 1'b1;
    DATA_IN  = w;
    step();
    VALID_IN = hold_v;
    DATA_IN  = next_d;
    for (int c = 0; c < NB * BD; c++) begin
      check($sformatf("%s c%0d", name, c + 1), 32'(main_outs()),
            32'({fr[c / BD], 1'b0, 1'b1, (c == NB * BD - 1)}));
      step();
    end
    check($sformatf("%s idle", name), 32'(main_outs()), 32'(4'b1100));
  endtask

  initial begin
    logic [7:0]  w;
    logic [10:0] fr;
    int          dcnt;

    vecs[0] = '{8'hA5, 1'b0, "a5"};
    vecs[1] = '{8'h07, 1'b1, "07"};
    vecs[2] = '{8'h03, 1'b0, "03"};
    vecs[3] = '{8'h81, 1'b0, "81"};

    RN = 1'b0;
    VALID_IN = 1'b0;
    DATA_IN = 8'h00;
    v1 = 1'b0;
    d1 = 8'h00;
    repeat (2) step();
    check("reset", 32'(main_outs()), 32'(4'b1100));
    check("reset fast", 32'({tx1, r1, b1, dn1}), 32'(4'b1100));
    RN = 1'b1;
    step();

    // Table-driven frames with hand-written expected parity.
    foreach (vecs[i])
      send_frame(vecs[i].data, table_frame(vecs[i].data, vecs[i].par), 1'b0,
                 8'($urandom), vecs[i].name);

    // Back-to-back: VALID held; DATA switches to 0xFF right after the first accept.
    // send_frame's last check is the single idle cycle; the next call accepts on that edge.
    send_frame(8'h00, table_frame(8'h00, 1'b0), 1'b1, 8'hFF, "b2b0");
    send_frame(8'hFF, table_frame(8'hFF, 1'b0), 1'b0, 8'h00, "b2b1");
    step();

    // Reset during data bit 3 (frame bit 4).
    w = 8'h5A;
    VALID_IN = 1'b1;
    DATA_IN  = w;
    step();
    VALID_IN = 1'b0;
    repeat (17) step();
    check("midrst bit3", 32'(main_outs()), 32'({w[3], 3'b010}));
    RN = 1'b0;
    step();
    check("midrst after", 32'(main_outs()), 32'(4'b1100));
    RN = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (DONE_OUT === 1'b1 || BUSY_OUT !== 1'b0) dcnt++;
    end
    check("midrst no done/busy", 32'(dcnt), 32'd0);
    w = 8'($urandom);
    send_frame(w, model_frame(w), 1'b0, 8'($urandom), "midrst next");

    // Randomized frames against the reference model, with random idle gaps.
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 3)) begin
        step();
        check("rand gap", 32'(main_outs()), 32'(4'b1100));
      end
      w = 8'($urandom);
      send_frame(w, model_frame(w), 1'($urandom_range(0, 1)) & 1'b0, 8'($urandom),
                 $sformatf("rand%0d_%02h", n, w));
    end

    // Reset held two cycles while idle.
    RN = 1'b0;
    step();
    step();
    check("idle reset", 32'(main_outs()), 32'(4'b1100));
    RN = 1'b1;
    step();

    // BAUD_DIV=1: 0x81 on consecutive cycles; a VALID pulse mid-frame is ignored.
    fr = table_frame(8'h81, 1'b0);
    v1 = 1'b1;
    d1 = 8'h81;
    step();
    v1 = 1'b0;
    d1 = 8'($urandom);
    for (int c = 0; c < NB; c++) begin
      if (c == 2) v1 = 1'b1;
      if (c == 3) v1 = 1'b0;
      check($sformatf("fast c%0d", c + 1), 32'({tx1, r1, b1, dn1}),
            32'({fr[c], 1'b0, 1'b1, (c == NB - 1)}));
      step();
    end
    check("fast idle1", 32'({tx1, r1, b1, dn1}), 32'(4'b1100));
    step();
    check("fast idle2", 32'({tx1, r1, b1, dn1}), 32'(4'b1100));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
